aes_key_expander: RTL and testbench

Downstream neighbour of the AHB receiver. Takes the committed 128-bit keyWord and expands it iteratively into the 11 AES-128 round keys (rk0..rk10), one round key per clock. The keys are held in an internal register file. The AES round datapath reads them through an indexed, registered read port. The block handshakes with the receiver/controller through key_load, busy and keys_valid.

---
 rtl/aes_key_expander.sv | 139 +++++++++++++
 tb/tb_aes_key_expander.sv | 138 +++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - AES-128 key schedule, one round key per clock, registered indexed read port
module aes_key_expander #(
  parameter int NUM_ROUNDS = 10,
  parameter int IDX_W      = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [127:0]     keyWord,
  input  logic             key_load,
  input  logic [IDX_W-1:0] rk_index,
  output logic [127:0]     round_key,
  output logic             busy,
  output logic             keys_valid
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  // Forward S-box, byte x lives at bits [(255-x)*8 +: 8]
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] rk_q [0:NUM_ROUNDS];
  logic [127:0] round_key_q;
  logic [127:0] prev_rk;
  logic [127:0] next_rk;
  logic [3:0]   prev_idx;
  logic [7:0]   rcon;
  logic [31:0]  rot_w, sub_w, temp_w;
  logic [31:0]  w0n, w1n, w2n, w3n;
  logic         load_ok;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  assign load_ok = key_load && (state_q != EXPAND);

  // State and round counter register
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: a load is only honoured outside EXPAND; EXPAND runs until counter hits the last round
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (key_load) begin
          state_d = EXPAND;
          cnt_d   = 4'd1;
        end
      end
      EXPAND: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(NUM_ROUNDS)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state
  always_comb begin
    busy       = (state_q == EXPAND);
    keys_valid = (state_q == DONE);
  end

  // Round constant for the round currently being produced
  always_comb begin
    case (cnt_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // One key-schedule step from the previous round key
  always_comb begin
    prev_idx = cnt_q - 4'd1;
    prev_rk  = (prev_idx <= 4'(NUM_ROUNDS)) ? rk_q[prev_idx] : 128'h0;
    rot_w    = {prev_rk[23:0], prev_rk[31:24]};
    sub_w    = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    temp_w   = sub_w ^ {rcon, 24'h0};
    w0n      = prev_rk[127:96] ^ temp_w;
    w1n      = prev_rk[95:64]  ^ w0n;
    w2n      = prev_rk[63:32]  ^ w1n;
    w3n      = prev_rk[31:0]   ^ w2n;
    next_rk  = {w0n, w1n, w2n, w3n};
  end

  // Round-key file: rk0 from the load, rk1..rk10 written one per EXPAND cycle
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= 128'h0;
    end else if (load_ok) begin
      rk_q[0] <= keyWord;
    end else if (state_q == EXPAND) begin
      rk_q[cnt_q] <= next_rk;
    end
  end

  // Registered read port; sees the file contents before this edge's write
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      round_key_q <= 128'h0;
    end else if (rk_index <= IDX_W'(NUM_ROUNDS)) begin
      round_key_q <= rk_q[rk_index];
    end else begin
      round_key_q <= 128'h0;
    end
  end

  assign round_key = round_key_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - directed checks of the AES-128 key expander against FIPS-197 vectors
module tb_aes_key_expander;

  localparam logic [127:0] FIPS_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic [127:0] keyWord;
  logic         key_load;
  logic [3:0]   rk_index;
  logic [127:0] round_key;
  logic         busy;
  logic         keys_valid;

  int n_vec = 0;
  int n_err = 0;

  aes_key_expander #(.NUM_ROUNDS(10), .IDX_W(4)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .keyWord   (keyWord),
    .key_load  (key_load),
    .rk_index  (rk_index),
    .round_key (round_key),
    .busy      (busy),
    .keys_valid(keys_valid)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [3:0] idx, input logic [127:0] exp);
    rk_index = idx;
    tick();
    chk(tag, round_key, exp);
  endtask

  task automatic status(input string tag, input logic exp_busy, input logic exp_valid);
    chk({tag, "_busy"}, {127'h0, busy}, {127'h0, exp_busy});
    chk({tag, "_valid"}, {127'h0, keys_valid}, {127'h0, exp_valid});
  endtask

  task automatic run_load(input string tag, input logic [127:0] key);
    keyWord  = key;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    status({tag, "_e0"}, 1'b1, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      tick();
      status({tag, "_mid"}, 1'b1, 1'b0);
    end
    tick();
    status({tag, "_e10"}, 1'b0, 1'b1);
  endtask

  initial begin
    HRESETn  = 1'b0;
    key_load = 1'b1;
    keyWord  = {$urandom, $urandom, $urandom, $urandom};
    rk_index = 4'd0;
    tick();
    tick();
    status("reset", 1'b0, 1'b0);
    chk("reset_round_key", round_key, 128'h0);
    HRESETn  = 1'b1;
    key_load = 1'b0;
    for (int i = 0; i <= 10; i++) rd("reset_rk", 4'(i), 128'h0);

    run_load("fips", FIPS_K);
    rd("fips_rk0", 4'd0, FIPS_K);
    rd("fips_rk1", 4'd1, FIPS_R1);
    rd("fips_rk10", 4'd10, FIPS_R10);

    run_load("zero_reload", 128'h0);
    rd("zero_rk0", 4'd0, 128'h0);
    rd("zero_rk1", 4'd1, ZERO_R1);
    rd("zero_rk10", 4'd10, ZERO_R10);
    rd("zero_rk11", 4'd11, 128'h0);
    rd("zero_rk15", 4'd15, 128'h0);

    keyWord  = FIPS_K;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    status("ign_e0", 1'b1, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      if (c == 4) begin
        keyWord  = 128'h00112233445566778899aabbccddeeff;
        key_load = 1'b1;
      end
      tick();
      key_load = 1'b0;
      status("ign_mid", 1'b1, 1'b0);
    end
    tick();
    status("ign_e10", 1'b0, 1'b1);
    rd("ign_rk0", 4'd0, FIPS_K);
    rd("ign_rk1", 4'd1, FIPS_R1);
    rd("ign_rk10", 4'd10, FIPS_R10);

    keyWord  = FIPS_K;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    status("midrst_pre", 1'b1, 1'b0);
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    status("midrst", 1'b0, 1'b0);
    chk("midrst_round_key", round_key, 128'h0);
    for (int i = 0; i <= 10; i++) rd("midrst_rk", 4'(i), 128'h0);
    run_load("after_rst", 128'h0);
    rd("after_rst_rk1", 4'd1, ZERO_R1);
    rd("after_rst_rk10", 4'd10, ZERO_R10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
